// File: rtl/burst_rom.sv
// rtl/burst_rom.sv - clocked burst ROM/RAM with wrap-around bursts and error flags
// Registered reads, auto-increment bursts on a shared tri-state data bus.
module burst_rom #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16,
   parameter int DEPTH      = 65536,
   parameter int WRITABLE   = 1,
   parameter int LEN_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rom_enable,
   input  logic                  rd_en,
   input  logic                  wr_en,
   input  logic [LEN_WIDTH-1:0]  burst_len,
   input  logic [ADDR_WIDTH-1:0] address_bus,
   inout  wire  [DATA_WIDTH-1:0] data_bus,
   output logic                  data_valid,
   output logic                  busy,
   output logic                  wr_err,
   output logic                  cmd_err
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD_BURST,
      S_WR_BURST
   } state_t;

   state_t                state_q;
   logic [IW-1:0]         addr_q;
   logic [LEN_WIDTH-1:0]  cnt_q;
   logic                  dv_q;
   logic                  busy_q;
   logic                  wr_err_q;
   logic                  cmd_err_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  rd_go;
   logic                  wr_go;
   logic                  both_go;
   logic                  rd_beat;
   logic                  wr_beat;
   logic                  mem_we;
   logic [IW-1:0]         start_a;
   logic [IW-1:0]         mem_addr;

   // Beat decode: the first beat uses the bus address, later beats the running pointer.
   always_comb begin
      start_a  = address_bus[IW-1:0];
      rd_go    = (state_q == S_IDLE) && !rom_enable && rd_en && !wr_en;
      wr_go    = (state_q == S_IDLE) && !rom_enable && wr_en && !rd_en;
      both_go  = (state_q == S_IDLE) && !rom_enable && rd_en && wr_en;
      rd_beat  = !rst && (rd_go ||
                 ((state_q == S_RD_BURST) && !rom_enable && (cnt_q != '0)));
      wr_beat  = !rst && (wr_go ||
                 ((state_q == S_WR_BURST) && !rom_enable));
      mem_we   = wr_beat && (WRITABLE != 0);
      mem_addr = (state_q == S_IDLE) ? start_a : addr_q;
   end

   // Array and read register carry no reset so contents survive rst.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= data_bus;
      end
      if (rd_beat) begin
         rdata_q <= mem[mem_addr];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         cnt_q     <= '0;
         dv_q      <= 1'b0;
         busy_q    <= 1'b0;
         wr_err_q  <= 1'b0;
         cmd_err_q <= 1'b0;
      end else begin
         wr_err_q  <= wr_beat && (WRITABLE == 0);
         cmd_err_q <= both_go;
         case (state_q)
            S_IDLE: begin
               dv_q   <= 1'b0;
               busy_q <= 1'b0;
               if (rd_go) begin
                  state_q <= S_RD_BURST;
                  addr_q  <= start_a + IW'(1);
                  cnt_q   <= burst_len;
                  dv_q    <= 1'b1;
                  busy_q  <= 1'b1;
               end else if (wr_go && (burst_len != '0)) begin
                  state_q <= S_WR_BURST;
                  addr_q  <= start_a + IW'(1);
                  cnt_q   <= burst_len;
                  busy_q  <= 1'b1;
               end
            end
            S_RD_BURST: begin
               if (rom_enable || (cnt_q == '0)) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
                  dv_q    <= 1'b0;
                  busy_q  <= 1'b0;
               end else begin
                  addr_q <= addr_q + IW'(1);
                  cnt_q  <= cnt_q - LEN_WIDTH'(1);
               end
            end
            S_WR_BURST: begin
               // cnt_q counts the write beats still owed; the last one returns to idle.
               if (rom_enable || (cnt_q == LEN_WIDTH'(1))) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  addr_q <= addr_q + IW'(1);
                  cnt_q  <= cnt_q - LEN_WIDTH'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               dv_q    <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign data_bus   = dv_q ? rdata_q : {DATA_WIDTH{1'bz}};
   assign data_valid = dv_q;
   assign busy       = busy_q;
   assign wr_err     = wr_err_q;
   assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_burst_rom.sv
// tb/tb_burst_rom.sv - directed vector bench for burst_rom
// One writable and one read-only instance; each vector is one clock edge.
module tb_burst_rom;

   typedef struct {
      logic        en_n;
      logic        rd;
      logic        wr;
      logic [3:0]  len;
      logic [15:0] addr;
      logic        drv;
      logic [7:0]  wd;
      logic        dv;
      logic        bsy;
      logic        werr;
      logic        cerr;
      logic [7:0]  rx;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        a_en_n = 1'b1, a_rd = 1'b0, a_wr = 1'b0, a_drv = 1'b0;
   logic [3:0]  a_len  = 4'h0;
   logic [15:0] a_addr = 16'h0;
   logic [7:0]  a_wd   = 8'h0;
   logic        a_dv, a_bsy, a_werr, a_cerr;
   wire  [7:0]  a_bus;
   assign a_bus = a_drv ? a_wd : 8'bzzzz_zzzz;

   logic        b_en_n = 1'b1, b_rd = 1'b0, b_wr = 1'b0, b_drv = 1'b0;
   logic [3:0]  b_len  = 4'h0;
   logic [15:0] b_addr = 16'h0;
   logic [7:0]  b_wd   = 8'h0;
   logic        b_dv, b_bsy, b_werr, b_cerr;
   wire  [7:0]  b_bus;
   assign b_bus = b_drv ? b_wd : 8'bzzzz_zzzz;

   int n_vec = 0;
   int n_err = 0;
   vec_t vt[$];

   burst_rom #(.WRITABLE(1)) dut_a (
      .clk(clk), .rst(rst), .rom_enable(a_en_n), .rd_en(a_rd), .wr_en(a_wr),
      .burst_len(a_len), .address_bus(a_addr), .data_bus(a_bus),
      .data_valid(a_dv), .busy(a_bsy), .wr_err(a_werr), .cmd_err(a_cerr)
   );

   burst_rom #(.WRITABLE(0)) dut_b (
      .clk(clk), .rst(rst), .rom_enable(b_en_n), .rd_en(b_rd), .wr_en(b_wr),
      .burst_len(b_len), .address_bus(b_addr), .data_bus(b_bus),
      .data_valid(b_dv), .busy(b_bsy), .wr_err(b_werr), .cmd_err(b_cerr)
   );

   function automatic vec_t mk(logic en_n, logic rd, logic wr, logic [3:0] len,
                               logic [15:0] addr, logic drv, logic [7:0] wd,
                               logic dv, logic bsy, logic werr, logic cerr,
                               logic [7:0] rx);
      vec_t v;
      v.en_n = en_n; v.rd = rd; v.wr = wr; v.len = len; v.addr = addr;
      v.drv = drv; v.wd = wd; v.dv = dv; v.bsy = bsy; v.werr = werr;
      v.cerr = cerr; v.rx = rx;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [7:0] act,
                      input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input bit sel_b, input int idx);
      logic dv_v, bs_v, we_v, ce_v;
      logic [7:0] bus_v;
      if (sel_b) begin
         b_en_n = v.en_n; b_rd = v.rd; b_wr = v.wr; b_len = v.len;
         b_addr = v.addr; b_drv = v.drv; b_wd = v.wd;
      end else begin
         a_en_n = v.en_n; a_rd = v.rd; a_wr = v.wr; a_len = v.len;
         a_addr = v.addr; a_drv = v.drv; a_wd = v.wd;
      end
      @(posedge clk);
      #1;
      if (sel_b) begin
         dv_v = b_dv; bs_v = b_bsy; we_v = b_werr; ce_v = b_cerr; bus_v = b_bus;
      end else begin
         dv_v = a_dv; bs_v = a_bsy; we_v = a_werr; ce_v = a_cerr; bus_v = a_bus;
      end
      chk("data_valid", idx, 8'(dv_v), 8'(v.dv));
      chk("busy", idx, 8'(bs_v), 8'(v.bsy));
      chk("wr_err", idx, 8'(we_v), 8'(v.werr));
      chk("cmd_err", idx, 8'(ce_v), 8'(v.cerr));
      if (v.dv) chk("data_bus", idx, bus_v, v.rx);
   endtask

   task automatic chk_reset(input int idx);
      chk("rst_dv_a", idx, 8'(a_dv), 8'h00);
      chk("rst_busy_a", idx, 8'(a_bsy), 8'h00);
      chk("rst_werr_a", idx, 8'(a_werr), 8'h00);
      chk("rst_cerr_a", idx, 8'(a_cerr), 8'h00);
      chk("rst_dv_b", idx, 8'(b_dv), 8'h00);
      chk("rst_busy_b", idx, 8'(b_bsy), 8'h00);
   endtask

   initial begin
      //          en rd wr len addr      drv wd      dv bsy we ce rx
      vt.push_back(mk(1,0,0,0,16'h0000,0,8'h00, 0,0,0,0,8'h00));
      vt.push_back(mk(0,0,1,0,16'h0001,1,8'hAA, 0,0,0,0,8'h00));
      vt.push_back(mk(0,0,1,0,16'h13C4,1,8'hBB, 0,0,0,0,8'h00));
      vt.push_back(mk(0,1,0,0,16'h0001,0,8'h00, 1,1,0,0,8'hAA));
      vt.push_back(mk(0,1,0,0,16'h13C4,0,8'h00, 0,0,0,0,8'h00));
      vt.push_back(mk(0,1,0,0,16'h13C4,0,8'h00, 1,1,0,0,8'hBB));
      vt.push_back(mk(1,0,0,0,16'h0000,0,8'h00, 0,0,0,0,8'h00));
      // burst write across the wrap point, then burst read it back
      vt.push_back(mk(0,0,1,3,16'hFFFE,1,8'h11, 0,1,0,0,8'h00));
      vt.push_back(mk(0,0,0,0,16'h0000,1,8'h22, 0,1,0,0,8'h00));
      vt.push_back(mk(0,0,0,0,16'h0000,1,8'h33, 0,1,0,0,8'h00));
      vt.push_back(mk(0,0,0,0,16'h0000,1,8'h44, 0,0,0,0,8'h00));
      vt.push_back(mk(0,1,0,3,16'hFFFE,0,8'h00, 1,1,0,0,8'h11));
      vt.push_back(mk(0,1,1,0,16'h0000,0,8'h00, 1,1,0,0,8'h22));
      vt.push_back(mk(0,0,0,0,16'h0000,0,8'h00, 1,1,0,0,8'h33));
      vt.push_back(mk(0,0,0,0,16'h0000,0,8'h00, 1,1,0,0,8'h44));
      vt.push_back(mk(0,0,0,0,16'h0000,0,8'h00, 0,0,0,0,8'h00));
      vt.push_back(mk(0,1,0,0,16'h0000,0,8'h00, 1,1,0,0,8'h33));
      vt.push_back(mk(1,0,0,0,16'h0000,0,8'h00, 0,0,0,0,8'h00));
      vt.push_back(mk(0,1,0,0,16'h0001,0,8'h00, 1,1,0,0,8'h44));
      vt.push_back(mk(1,0,0,0,16'h0000,0,8'h00, 0,0,0,0,8'h00));
      // conflicting command
      vt.push_back(mk(0,1,1,0,16'h0001,1,8'h77, 0,0,0,1,8'h00));
      vt.push_back(mk(1,0,0,0,16'h0000,0,8'h00, 0,0,0,0,8'h00));
      vt.push_back(mk(0,1,0,0,16'h0001,0,8'h00, 1,1,0,0,8'h44));
      vt.push_back(mk(1,0,0,0,16'h0000,0,8'h00, 0,0,0,0,8'h00));
      vt.push_back(mk(1,1,1,0,16'h0001,0,8'h00, 0,0,0,0,8'h00));
      // preload then abort a long read burst after three beats
      vt.push_back(mk(0,0,1,3,16'h0100,1,8'h01, 0,1,0,0,8'h00));
      vt.push_back(mk(0,0,0,0,16'h0000,1,8'h02, 0,1,0,0,8'h00));
      vt.push_back(mk(0,0,0,0,16'h0000,1,8'h03, 0,1,0,0,8'h00));
      vt.push_back(mk(0,0,0,0,16'h0000,1,8'h04, 0,0,0,0,8'h00));
      vt.push_back(mk(0,1,0,7,16'h0100,0,8'h00, 1,1,0,0,8'h01));
      vt.push_back(mk(0,0,0,0,16'h0000,0,8'h00, 1,1,0,0,8'h02));
      vt.push_back(mk(0,0,0,0,16'h0000,0,8'h00, 1,1,0,0,8'h03));
      vt.push_back(mk(1,0,0,0,16'h0000,0,8'h00, 0,0,0,0,8'h00));
      vt.push_back(mk(0,1,0,0,16'h0103,0,8'h00, 1,1,0,0,8'h04));
      vt.push_back(mk(1,0,0,0,16'h0000,0,8'h00, 0,0,0,0,8'h00));

      @(posedge clk);
      #1;
      chk_reset(0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < vt.size(); i++) apply(vt[i], 1'b0, i);

      // reset lands in the middle of a burst write, after two beats
      apply(mk(0,0,1,3,16'h0200,1,8'hA1, 0,1,0,0,8'h00), 1'b0, 100);
      apply(mk(0,0,0,0,16'h0000,1,8'hA2, 0,1,0,0,8'h00), 1'b0, 101);
      #1;
      rst = 1'b1;
      a_drv = 1'b0; a_en_n = 1'b1;
      #1;
      chk_reset(102);
      @(posedge clk);
      #1;
      rst = 1'b0;
      apply(mk(0,1,0,0,16'h0200,0,8'h00, 1,1,0,0,8'hA1), 1'b0, 103);
      apply(mk(1,0,0,0,16'h0000,0,8'h00, 0,0,0,0,8'h00), 1'b0, 104);
      apply(mk(0,1,0,0,16'h0201,0,8'h00, 1,1,0,0,8'hA2), 1'b0, 105);
      apply(mk(1,0,0,0,16'h0000,0,8'h00, 0,0,0,0,8'h00), 1'b0, 106);
      apply(mk(0,1,0,0,16'h0202,0,8'h00, 1,1,0,0,8'h00), 1'b0, 107);
      apply(mk(1,0,0,0,16'h0000,0,8'h00, 0,0,0,0,8'h00), 1'b0, 108);

      // read-only instance: writes are flagged and never land
      apply(mk(0,0,1,0,16'h0010,1,8'h5A, 0,0,1,0,8'h00), 1'b1, 200);
      apply(mk(1,0,0,0,16'h0000,0,8'h00, 0,0,0,0,8'h00), 1'b1, 201);
      apply(mk(0,1,0,0,16'h0010,0,8'h00, 1,1,0,0,8'h00), 1'b1, 202);
      apply(mk(1,0,0,0,16'h0000,0,8'h00, 0,0,0,0,8'h00), 1'b1, 203);
      apply(mk(0,0,1,1,16'h0011,1,8'h5A, 0,1,1,0,8'h00), 1'b1, 204);
      apply(mk(0,0,0,0,16'h0000,1,8'h5B, 0,0,1,0,8'h00), 1'b1, 205);
      apply(mk(1,0,0,0,16'h0000,0,8'h00, 0,0,0,0,8'h00), 1'b1, 206);
      apply(mk(0,1,0,1,16'h0011,0,8'h00, 1,1,0,0,8'h00), 1'b1, 207);
      apply(mk(0,0,0,0,16'h0000,0,8'h00, 1,1,0,0,8'h00), 1'b1, 208);
      apply(mk(1,0,0,0,16'h0000,0,8'h00, 0,0,0,0,8'h00), 1'b1, 209);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/burst_rom.md
Name: burst_rom

Overview:
Parametrised, clocked successor to the team's asynchronous 8-bit ROM model.
- Memory array shared with the CPU over an active-low-enabled bidirectional data bus.
- Adds registered reads, auto-incrementing burst transfers with wrap-around, an optional write path for simulation preload, and error/status flags.
- Sits on the system memory bus alongside RAM; the bus master drives address, enables and (on writes) data.

Parameters:
DATA_WIDTH, 8, data bus and word width
ADDR_WIDTH, 16, address bus width
DEPTH, 65536, implemented words; address used modulo DEPTH (DEPTH power of two, ≤ 2^ADDR_WIDTH)
WRITABLE, 1, 1 = writes update the array; 0 = read-only, writes rejected
LEN_WIDTH, 4, width of burst_len

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
rom_enable  in  1  active-low chip enable
rd_en  in  1  read request
wr_en  in  1  write request
burst_len  in  LEN_WIDTH  extra beats after the first (0 = single transfer)
address_bus  in  ADDR_WIDTH  start word address
data_bus  inout  DATA_WIDTH  driven by block only while data_valid=1, else high-Z
data_valid  out  1  data_bus carries a read beat this cycle
busy  out  1  burst in progress; new commands ignored
wr_err  out  1  one-cycle pulse: write rejected (WRITABLE=0)
cmd_err  out  1  one-cycle pulse: rd_en and wr_en both high at acceptance

Behaviour:
- Reset (async, any time): state=IDLE, data_valid=0, busy=0, wr_err=0, cmd_err=0, data_bus high-Z, beat counter and address register cleared. Memory contents are NOT cleared by reset; the array is zero at time 0.
- States: IDLE, RD_BURST, WR_BURST. busy = (state != IDLE).
- Acceptance (IDLE only): at a rising edge with rom_enable=0.
  - rd_en=1, wr_en=0 → read
  - wr_en=1, rd_en=0 → write
  - Both high → no transfer, cmd_err=1 next cycle, stay IDLE.
  - Neither → nothing.
  - Commands while busy are ignored with no flags.
- Address: A = address_bus mod DEPTH. Beat i uses (A+i) mod DEPTH, wrapping DEPTH-1 → 0.
- Read, accepted at edge T:
  - Registered data = mem[A]; data_valid=1 during cycle T..T+1 (one-cycle latency).
  - burst_len=L>0 → state RD_BURST; one beat per cycle, mem[A+1]..mem[A+L], data_valid continuously high for L+1 cycles.
  - After the last beat: data_valid=0, bus released, IDLE.
  - Single read (L=0) enters RD_BURST for its single data cycle, so busy=1 while data_valid=1.
- Write, accepted at edge T:
  - data_bus sampled at edge T into A.
  - L>0 → WR_BURST; data_bus sampled at edges T+1..T+L into A+1..A+L, then IDLE.
  - L=0 → remains IDLE, busy stays 0.
- WRITABLE=0:
  - Array never modified.
  - Each rejected write beat produces wr_err=1 for the following cycle.
  - Burst sequencing proceeds normally so the master's timing is unchanged.
- Read-after-write: a write at edge T followed by a read accepted at T+1 returns the new value.
- Abort: rom_enable=1 sampled at any edge in RD_BURST/WR_BURST.
  - Beat not performed; state → IDLE; data_valid=0, data_bus high-Z next cycle.
  - Already-written beats remain.
- Bus contention rule: block never drives data_bus in WR_BURST or IDLE.
- burst_len sampled only at acceptance; later changes ignored.

Test Plan:
- Single write 0xAA @0x0001, single write 0xBB @0x13C4, then single reads of each → data_valid one cycle after acceptance, data_bus=0xAA then 0xBB; high-Z otherwise.
- Burst write burst_len=3 @0xFFFE, data 0x11,0x22,0x33,0x44 → burst read burst_len=3 @0xFFFE returns 0x11,0x22,0x33,0x44 on four consecutive cycles; addresses 0x0000/0x0001 hold 0x33/0x44 (wrap); busy high exactly 4 cycles.
- WRITABLE=0 instance: write 0x5A @0x0010 → wr_err pulses one cycle, subsequent read returns 0x00.
- rd_en=wr_en=1 with rom_enable=0 → cmd_err one-cycle pulse, no data_valid, memory unchanged.
- Burst read burst_len=7 @0x0100; raise rom_enable after beat 2 → data_valid drops next cycle, busy=0, bus high-Z; an immediate new single read is accepted.
- Assert rst mid burst-write after 2 beats → outputs immediately at reset values; the two written words persist, remaining addresses unchanged.
